// File: rtl/spram_master.sv
// spram_master
//   Request-side controller for a single-port RAM with registered read data.
//   Read/write commands arrive on a ready/valid request channel and are passed
//   straight through to the RAM pins. Read data comes back one cycle after
//   issue and is buffered in a 4-entry FIFO that feeds the response channel.
//   A credit counter (FIFO occupancy + reads in flight) stops new requests
//   once all four response slots are spoken for, so the FIFO cannot overflow.
//
//   Optional feature, macro SPRAM_MASTER_INIT_CLEAR_EN:
//     when defined, an INIT state sweeps the RAM with zeros after reset
//     release (one address per cycle) before requests are accepted.
//
// Ports
//   clk, resetn              clock, synchronous active-low reset
//   req_valid/req_ready      request handshake
//   req_write/addr/wdata     request payload (1 = write)
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata                read data, in request order
//   mem_en/wen/addr/din      RAM control and write data
//   mem_dout                 RAM registered read data
//   busy                     initialization sweep in progress
module spram_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_en,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  busy
);

  localparam int FIFO_DEPTH = 4;

`ifdef SPRAM_MASTER_INIT_CLEAR_EN
  typedef enum logic {ST_RUN = 1'b0, ST_INIT = 1'b1} state_e;
  localparam state_e RST_STATE = ST_INIT;
`else
  typedef enum logic {ST_RUN = 1'b0} state_e;
  localparam state_e RST_STATE = ST_RUN;
`endif

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;       // occupancy + reads in flight
  logic                  rd_pend_q, rd_pend_d;
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [2:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_d [FIFO_DEPTH];
`ifdef SPRAM_MASTER_INIT_CLEAR_EN
  logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;
`endif

  logic req_acc, rd_acc, push, pop;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_pend_d = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    fifo_d    = fifo_q;
`ifdef SPRAM_MASTER_INIT_CLEAR_EN
    init_addr_d = init_addr_q;
`endif

    // Outputs are gated by resetn so reset takes effect in the same cycle,
    // before the synchronous clear reaches the registers.
    req_ready = resetn && (state_q == ST_RUN) && (cnt_q < 3'd4);
    req_acc   = req_valid && req_ready;
    rd_acc    = req_acc && !req_write;
    rsp_valid = resetn && (occ_q != 3'd0);
    rsp_rdata = resetn ? fifo_q[rd_ptr_q] : '0;
    pop       = rsp_valid && rsp_ready;
    push      = rd_pend_q;

    mem_en   = 1'b0;
    mem_wen  = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (req_acc) begin
      mem_en   = 1'b1;
      mem_wen  = req_write;
      mem_addr = req_addr;
      mem_din  = req_wdata;
    end

`ifdef SPRAM_MASTER_INIT_CLEAR_EN
    busy = !resetn || (state_q == ST_INIT);
    if (resetn && state_q == ST_INIT) begin
      mem_en      = 1'b1;
      mem_wen     = 1'b1;
      mem_addr    = init_addr_q;
      init_addr_d = init_addr_q + 1'b1;
      if (&init_addr_q) state_d = ST_RUN;
    end
`else
    busy = 1'b0;
`endif

    // A pop only returns credit through cnt_q, i.e. from the next cycle.
    cnt_d     = cnt_q + {2'b00, rd_acc} - {2'b00, pop};
    rd_pend_d = rd_acc;

    // RAM data is valid the cycle after issue; capture it then.
    if (push) begin
      fifo_d[wr_ptr_q] = mem_dout;
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 3'd1;
      2'b01:   occ_d = occ_q - 3'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= RST_STATE;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
`ifdef SPRAM_MASTER_INIT_CLEAR_EN
      init_addr_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= fifo_d[i];
`ifdef SPRAM_MASTER_INIT_CLEAR_EN
      init_addr_q <= init_addr_d;
`endif
    end
  end

endmodule

// File: tb/tb_spram_master.sv
// Bench for spram_master: drives directed requests, models the RAM,
// and checks responses through an expected-data queue popped by a monitor.
module tb_spram_master;
  localparam int DW = 32;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid, mem_en, mem_wen, busy;
  logic [DW-1:0] rsp_rdata, mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic [AW-1:0] mem_addr;

  spram_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  // single-port RAM with registered read data
  logic [DW-1:0] ram [1<<AW];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wen) ram[mem_addr] <= mem_din;
      else         mem_dout <= ram[mem_addr];
    end
  end

  int checks = 0, errors = 0;
  int cyc = 0;
  logic [DW-1:0] exp_q [$];
  int rsp_cyc_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every response handshake is compared to the oldest expectation
  always @(negedge clk) begin
    if (resetn && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got %0h expected no response", rsp_rdata);
      end else begin
        chk("rsp_data", rsp_rdata, exp_q.pop_front());
      end
      rsp_cyc_q.push_back(cyc);
    end
    assert (dut.occ_q <= 3'd4) else $error("response buffer overflow");
  end

  // Holds a request for up to max_wait cycles; returns acceptance and cycle.
  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] exp, input int max_wait,
                       output bit acc, output int acc_cyc);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    acc = 1'b0; acc_cyc = -1;
    for (int i = 0; i < max_wait && !acc; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = 1'b1;
        acc_cyc = cyc;
        chk("mem_en_acc", mem_en, 1);
        chk("mem_wen_acc", mem_wen, wr);
        chk("mem_addr_acc", mem_addr, a);
        chk("mem_din_acc", mem_din, d);
        if (!wr) exp_q.push_back(exp);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      seen = req_ready;
      @(posedge clk); #1;
    end
    chk("ready_after_reset", seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    int c0, c1, n, stale;
    int ac [6];

    // reset values, with a request offered to show the pins stay quiet
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd3; req_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
`ifdef SPRAM_MASTER_INIT_CLEAR_EN
    chk("rst_busy", busy, 1);
`else
    chk("rst_busy", busy, 0);
`endif
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    resetn = 1'b1;

`ifdef SPRAM_MASTER_INIT_CLEAR_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("init_mem_en", mem_en, 1);
      chk("init_mem_wen", mem_wen, 1);
      chk("init_mem_addr", mem_addr, i);
      chk("init_mem_din", mem_din, 0);
      chk("init_busy", busy, 1);
      chk("init_req_ready", req_ready, 0);
      @(posedge clk); #1;
    end
`endif
    @(negedge clk);
    chk("run_req_ready", req_ready, 1);
    chk("run_busy", busy, 0);
    @(posedge clk); #1;

    // write then read-after-write
    rsp_ready = 1'b1;
    rsp_cyc_q.delete();
    issue(1'b1, 2'd2, 32'hDEAD_BEEF, '0, 4, acc, c0);
    chk("raw_wr_acc", acc, 1);
    issue(1'b0, 2'd2, '0, 32'hDEAD_BEEF, 4, acc, c1);
    chk("raw_rd_cycle", c1, c0 + 1);
    drain(10);
    chk("raw_rsp_count", rsp_cyc_q.size(), 1);
    if (rsp_cyc_q.size() == 1) chk("raw_rsp_cycle", rsp_cyc_q[0], c0 + 3);

    // streaming reads
    for (int i = 0; i < 4; i++) issue(1'b1, AW'(i), 32'h10 + i, '0, 4, acc, c0);
    rsp_cyc_q.delete();
    for (int i = 0; i < 4; i++) issue(1'b0, AW'(i), '0, 32'h10 + i, 4, acc, ac[i]);
    for (int i = 1; i < 4; i++) chk("stream_acc_cycle", ac[i], ac[0] + i);
    drain(12);
    chk("stream_rsp_count", rsp_cyc_q.size(), 4);
    if (rsp_cyc_q.size() == 4) begin
      chk("stream_first_rsp", rsp_cyc_q[0], ac[0] + 2);
      for (int i = 1; i < 4; i++) chk("stream_rsp_cycle", rsp_cyc_q[i], rsp_cyc_q[0] + i);
    end

    // backpressure: six offers, four credits
    rsp_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, AW'(i % 4), '0, 32'h10 + (i % 4), 1, acc, ac[i]);
      n += int'(acc);
    end
    chk("bp_accepted", n, 4);
    @(negedge clk);
    chk("bp_ready_full", req_ready, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_pop_valid", rsp_valid, 1);
    chk("bp_ready_pop_cycle", req_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_ready_after_pop", req_ready, 1);
    @(posedge clk); #1;
    drain(12);

    // write offered with all credits taken
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(1'b0, 2'd3, '0, 32'h13, 2, acc, c0);
    issue(1'b1, 2'd3, 32'hBAD0_BAD0, '0, 3, acc, c0);
    chk("full_wr_blocked", acc, 0);
    rsp_ready = 1'b1;
    drain(12);
    issue(1'b0, 2'd3, '0, 32'h13, 4, acc, c0);
    drain(10);

    // reset with two reads in flight
    rsp_ready = 1'b0;
    issue(1'b0, 2'd0, '0, 32'h10, 4, acc, c0);
    issue(1'b0, 2'd1, '0, 32'h11, 4, acc, c1);
    resetn = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd1;
    @(negedge clk);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_mem_en", mem_en, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    exp_q.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
    req_valid = 1'b0; req_addr = '0;
    rsp_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) stale++;
      @(posedge clk); #1;
    end
    chk("mid_rst_no_stale", stale, 0);
    wait_ready(8);
`ifdef SPRAM_MASTER_INIT_CLEAR_EN
    issue(1'b0, 2'd2, '0, 32'h0, 4, acc, c0);
`else
    issue(1'b0, 2'd2, '0, 32'h12, 4, acc, c0);
`endif
    drain(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
